// File: rtl/taylor_pkg.sv
// Shared fixed-point types and arbiter FSM state encoding for the taylor cosine arbiter.
package taylor_pkg;

   localparam int unsigned FXP_W    = 24;
   localparam int unsigned FXP_FRAC = 10;
   localparam logic [23:0] FXP_ONE  = 24'd1024;

   typedef logic [FXP_W-1:0] fxp_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RESP
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid request at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter
   import taylor_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] gnt_idx_o,
   output logic                    gnt_valid_o
);

   localparam int unsigned IdW = $clog2(NREQ);

   int unsigned       idx;
   logic [IdW-1:0]    idx_w;

   // Scan from the pointer upwards; the first hit wins.
   always_comb begin
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      idx         = 0;
      idx_w       = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         idx   = (32'(ptr_i) + off) % NREQ;
         idx_w = IdW'(idx);
         if (!gnt_valid_o && req_i[idx_w]) begin
            gnt_valid_o  = 1'b1;
            gnt_o[idx_w] = 1'b1;
            gnt_idx_o    = idx_w;
         end
      end
   end

endmodule

// File: rtl/taylor_cos_arbiter.sv
// Shares one taylor_rtl cosine core between NREQ requesters with round-robin arbitration.
// Optional watchdog enabled by defining TAYLOR_ARB_TIMEOUT_EN.
module taylor_cos_arbiter
   import taylor_pkg::*;
#(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned START_CYCLES   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*FXP_W-1:0]   req_angle,
   output logic [NREQ-1:0]         req_ready,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [$clog2(NREQ)-1:0] resp_id,
   output fxp_t                    resp_cos,
   output logic                    resp_err,
   output logic                    core_start,
   output fxp_t                    core_angle,
   input  logic                    core_ready,
   input  fxp_t                    core_cos,
   output logic                    busy
);

   localparam int unsigned IdW        = $clog2(NREQ);
   localparam int unsigned StW        = $clog2(START_CYCLES + 1);
   localparam logic [StW-1:0] ST_LAST = StW'(START_CYCLES - 1);

   arb_state_t     state_q, state_d;
   logic [IdW-1:0] ptr_q, ptr_d;
   logic [IdW-1:0] id_q, id_d;
   fxp_t           angle_q, angle_d;
   logic [StW-1:0] st_cnt_q, st_cnt_d;
   logic           ready_q;
   logic           resp_valid_q, resp_valid_d;
   logic [IdW-1:0] resp_id_q, resp_id_d;
   fxp_t           resp_cos_q, resp_cos_d;
   logic           resp_err_q, resp_err_d;

   logic [NREQ-1:0] gnt;
   logic [IdW-1:0]  gnt_idx;
   logic            gnt_valid;
   logic            done;

`ifdef TAYLOR_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_q, wd_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr (
      .req_i      (req_valid),
      .ptr_i      (ptr_q),
      .gnt_o      (gnt),
      .gnt_idx_o  (gnt_idx),
      .gnt_valid_o(gnt_valid)
   );

   // Only a fresh rising edge counts; a level left over from the last operation is ignored.
   assign done = core_ready & ~ready_q;

   // Next-state, grant and response capture.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      id_d         = id_q;
      angle_d      = angle_q;
      st_cnt_d     = st_cnt_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_cos_d   = resp_cos_q;
      resp_err_d   = resp_err_q;
      req_ready    = '0;
`ifdef TAYLOR_ARB_TIMEOUT_EN
      wd_d         = wd_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               req_ready = reset ? '0 : gnt;
               angle_d   = req_angle[gnt_idx*FXP_W +: FXP_W];
               id_d      = gnt_idx;
               ptr_d     = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
               st_cnt_d  = '0;
               state_d   = START;
            end
         end
         START: begin
            if (st_cnt_q == ST_LAST) begin
               state_d = WAIT;
`ifdef TAYLOR_ARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end else begin
               st_cnt_d = st_cnt_q + 1'b1;
            end
         end
         WAIT: begin
            if (done) begin
               resp_valid_d = 1'b1;
               resp_id_d    = id_q;
               resp_cos_d   = core_cos;
               resp_err_d   = 1'b0;
               state_d      = RESP;
`ifdef TAYLOR_ARB_TIMEOUT_EN
            end else if (wd_q == WD_LAST) begin
               resp_valid_d = 1'b1;
               resp_id_d    = id_q;
               resp_cos_d   = '0;
               resp_err_d   = 1'b1;
               state_d      = RESP;
            end else begin
               wd_d = wd_q + 1'b1;
`endif
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any in-flight operation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         id_q         <= '0;
         angle_q      <= '0;
         st_cnt_q     <= '0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_cos_q   <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         id_q         <= id_d;
         angle_q      <= angle_d;
         st_cnt_q     <= st_cnt_d;
         ready_q      <= core_ready;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_cos_q   <= resp_cos_d;
         resp_err_q   <= resp_err_d;
      end
   end

`ifdef TAYLOR_ARB_TIMEOUT_EN
   // Watchdog counter for the WAIT state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`endif

   assign core_start = (state_q == START);
   assign core_angle = angle_q;
   assign busy       = (state_q != IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_cos   = resp_cos_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_taylor_cos_arbiter.sv
// Directed self-checking bench for taylor_cos_arbiter with a behavioural cosine core.
module tb_taylor_cos_arbiter;

   localparam int NREQ = 4;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [3:0]     req_valid = '0;
   logic [95:0]    req_angle = '0;
   logic [3:0]     req_ready;
   logic           resp_valid;
   logic           resp_ready = 1'b0;
   logic [1:0]     resp_id;
   logic [23:0]    resp_cos;
   logic           resp_err;
   logic           core_start;
   logic [23:0]    core_angle;
   logic           core_ready = 1'b0;
   logic [23:0]    core_cos = '0;
   logic           busy;

   int n_cmp = 0;
   int n_err = 0;

   // Monitor state
   logic [3:0] last_gnt = '0;
   int         n_gnt = 0;
   int         n_start = 0;
   int         n_wait = 0;
   int         gnt_log[$];

   // Core model controls
   int          core_lat = 4;
   bit          stale_mode = 1'b0;
   bit          core_dead = 1'b0;
   int          core_cnt = 0;
   bit          running = 1'b0;
   logic [23:0] pend_angle = '0;

   taylor_cos_arbiter #(
      .NREQ          (NREQ),
      .START_CYCLES  (3),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_angle (req_angle),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_id   (resp_id),
      .resp_cos  (resp_cos),
      .resp_err  (resp_err),
      .core_start(core_start),
      .core_angle(core_angle),
      .core_ready(core_ready),
      .core_cos  (core_cos),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [23:0] cos_of(input logic [23:0] a);
      case (a)
         24'd0:    return 24'd1024;
         24'd102:  return 24'd1019;
         24'd512:  return 24'd899;
         24'd1024: return 24'd553;
         default:  return 24'h00dead;
      endcase
   endfunction

   // Behavioural core: ready_out stays high after a result until the next start.
   always @(posedge clock) begin
      if (core_start) begin
         core_cnt   <= 0;
         running    <= 1'b1;
         pend_angle <= core_angle;
         if (!stale_mode) core_ready <= 1'b0;
      end else if (running) begin
         if (core_cnt == core_lat) begin
            running <= 1'b0;
            if (!core_dead) begin
               core_ready <= 1'b1;
               core_cos   <= cos_of(pend_angle);
            end
         end else begin
            core_cnt <= core_cnt + 1;
            if (stale_mode && core_cnt == core_lat - 1) core_ready <= 1'b0;
         end
      end
   end

   // Grant / start / wait-cycle monitor sampled at the active edge.
   always @(posedge clock) begin
      last_gnt <= req_ready;
      if (req_ready != 4'b0) begin
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_log.push_back(i);
         n_gnt <= n_gnt + 1;
      end
      if (core_start) n_start <= n_start + 1;
      if (busy && !core_start && !resp_valid) n_wait <= n_wait + 1;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: requesters drop valid after their grant edge; sample 1 unit after negedge.
   task automatic cyc();
      @(negedge clock);
      req_valid = req_valid & ~last_gnt;
      #1;
   endtask

   task automatic wait_resp(input string tag);
      int k;
      k = 0;
      while (resp_valid !== 1'b1 && k < 80) begin
         cyc();
         k++;
      end
      check({tag, "_valid"}, 32'(resp_valid), 32'd1);
   endtask

   task automatic take_resp(input string tag, input int id, input logic [23:0] cosv,
                            input logic err);
      wait_resp(tag);
      check({tag, "_id"}, 32'(resp_id), 32'(id));
      check({tag, "_cos"}, 32'(resp_cos), 32'(cosv));
      check({tag, "_err"}, 32'(resp_err), 32'(err));
      resp_ready = 1'b1;
      cyc();
      resp_ready = 1'b0;
      check({tag, "_drop"}, 32'(resp_valid), 32'd0);
   endtask

   int          base_g, base_s, base_l, base_w, bad;
   logic [23:0] snap_cos;
   logic [1:0]  snap_id;
   logic [23:0] exp_cos[4];

   initial begin
      exp_cos[0] = 24'd1024;
      exp_cos[1] = 24'd1019;
      exp_cos[2] = 24'd899;
      exp_cos[3] = 24'd553;

      // Reset state, including with requests pending during reset.
      cyc();
      cyc();
      check("rst_outs", {req_ready, resp_valid, resp_id, resp_err, core_start, busy}, 32'd0);
      check("rst_cos", 32'(resp_cos), 32'd0);
      check("rst_angle", 32'(core_angle), 32'd0);
      req_valid = 4'hf;
      #1;
      check("rst_no_grant", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      req_valid = 4'h0;
      cyc();
      reset = 1'b0;
      cyc();

      // Single request from requester 2.
      base_g = n_gnt;
      base_s = n_start;
      req_angle[24*2 +: 24] = 24'd0;
      req_angle[24*0 +: 24] = 24'd512;
      req_valid = 4'b0100;
      #1;
      check("t1_grant", 32'(req_ready), 32'b0100);
      take_resp("t1", 2, 24'd1024, 1'b0);
      check("t1_npulse", 32'(n_gnt - base_g), 32'd1);
      check("t1_nstart", 32'(n_start - base_s), 32'd3);
      check("t1_busy_end", 32'(busy), 32'd0);

      // Reset the pointer, then fairness with all four requesters.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      base_l = gnt_log.size();
      req_angle[24*0 +: 24] = 24'd0;
      req_angle[24*1 +: 24] = 24'd102;
      req_angle[24*2 +: 24] = 24'd512;
      req_angle[24*3 +: 24] = 24'd1024;
      req_valid = 4'hf;
      for (int i = 0; i < NREQ; i++) take_resp($sformatf("t2_%0d", i), i, exp_cos[i], 1'b0);
      check("t2_ngrant", 32'(gnt_log.size() - base_l), 32'd4);
      for (int i = 0; i < NREQ; i++)
         check($sformatf("t2_order%0d", i), 32'(gnt_log[base_l+i]), 32'(i));

      // Backpressure: response held 20 cycles, no new grant while requester 1 waits.
      req_valid = 4'b0011;
      wait_resp("t3");
      check("t3_id", 32'(resp_id), 32'd0);
      check("t3_cos", 32'(resp_cos), 32'd1024);
      snap_cos = resp_cos;
      snap_id  = resp_id;
      base_g   = n_gnt;
      bad      = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (resp_valid !== 1'b1 || resp_cos !== snap_cos || resp_id !== snap_id ||
             resp_err !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0) bad++;
      end
      check("t3_hold_stable", 32'(bad), 32'd0);
      check("t3_no_grant", 32'(n_gnt - base_g), 32'd0);
      resp_ready = 1'b1;
      cyc();
      resp_ready = 1'b0;
      check("t3_drop", 32'(resp_valid), 32'd0);
      check("t3_regrant", 32'(req_ready), 32'b0010);
      take_resp("t3b", 1, 24'd1019, 1'b0);

      // Stale ready: core keeps ready_out high; only the fresh edge counts.
      stale_mode = 1'b1;
      req_angle[24*3 +: 24] = 24'd512;
      req_valid = 4'b1000;
      take_resp("t4", 3, 24'd899, 1'b0);
      stale_mode = 1'b0;

      // Reset during WAIT discards the operation.
      base_g = n_gnt;
      req_angle[24*1 +: 24] = 24'd102;
      req_valid = 4'b0010;
      for (int i = 0; i < 5; i++) cyc();
      check("t5_in_wait", {core_start, busy, resp_valid}, 32'b010);
      reset = 1'b1;
      #1;
      check("t5_rst_outs", {req_ready, resp_valid, core_start, busy}, 32'd0);
      check("t5_rst_angle", 32'(core_angle), 32'd0);
      cyc();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (resp_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("t5_no_stale_resp", 32'(bad), 32'd0);
      req_valid = 4'b0010;
      #1;
      check("t5_regrant", 32'(req_ready), 32'b0010);
      take_resp("t5", 1, 24'd1019, 1'b0);
      check("t5_ngrant", 32'(n_gnt - base_g), 32'd2);

`ifdef TAYLOR_ARB_TIMEOUT_EN
      // Watchdog: core never answers.
      core_dead = 1'b1;
      base_w = n_wait;
      req_angle[24*2 +: 24] = 24'd512;
      req_valid = 4'b0100;
      take_resp("t6", 2, 24'd0, 1'b1);
      check("t6_wait_cycles", 32'(n_wait - base_w), 32'd16);
      core_dead = 1'b0;
      req_valid = 4'b0100;
      take_resp("t6b", 2, 24'd899, 1'b0);
`endif

      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/taylor_cos_arbiter.md
Name: taylor_cos_arbiter

Overview:
- Shares one taylor_rtl cosine core between NREQ requesters.
- Per-requester valid/ready request ports carry Q2.10 angles in 24-bit words.
- Arbitration is round-robin. The block sequences the core's start/ready_out handshake and returns the cosine tagged with the requester ID on a single valid/ready response port.
- Sits between the angle-producing clients and the taylor_rtl instance.

Parameters:
NREQ, 4, number of requesters (2..8)
START_CYCLES, 3, cycles core_start is held high per operation (min 1)
TIMEOUT_CYCLES, 255, watchdog limit in cycles, only used with TAYLOR_ARB_TIMEOUT_EN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  requester i has an angle pending
req_angle  in  NREQ*24  angle of requester i in bits [24*i+23:24*i], Q2.10
req_ready  out  NREQ  one-hot grant/accept pulse
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  $clog2(NREQ)  requester index of the result
resp_cos  out  24  cosine, Q2.10
resp_err  out  1  result produced by watchdog timeout
core_start  out  1  to taylor_rtl start
core_angle  out  24  to taylor_rtl angle_in
core_ready  in  1  from taylor_rtl ready_out
core_cos  in  24  from taylor_rtl cos_out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, rr pointer 0, and internal ready_q register 0.
- State machine: IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant one index g by round-robin.
  - Search order is ptr, ptr+1, … wrapping modulo NREQ.
  - In the same cycle, req_ready[g]=1 for exactly one cycle.
  - Latch req_angle[g] into core_angle and g into id_q. Set ptr <= (g+1) mod NREQ.
  - Go to START. If no request is valid, stay in IDLE.
- START:
  - core_start=1 for START_CYCLES consecutive cycles, with core_angle stable.
  - Then core_start=0 and go to WAIT.
- WAIT:
  - ready_q registers core_ready every cycle. Completion = core_ready & ~ready_q (rising edge).
  - A level-high core_ready left over from a previous operation does not count as completion.
  - On completion: capture core_cos into resp_cos, set resp_id=id_q, resp_err=0, resp_valid=1, and go to RESP.
- RESP:
  - Hold resp_valid, resp_id, resp_cos and resp_err stable until resp_ready=1.
  - On that cycle the transfer occurs. Next cycle resp_valid=0 and state is IDLE.
- Grant and outstanding-operation rules:
  - Single outstanding operation: no grants outside IDLE. Requesters simply hold req_valid.
  - Earliest possible new grant is the cycle after the response transfer.
  - req_valid deasserted before grant: no effect. req_angle changes after grant: no effect, because the angle is latched.
- Latency: grant to resp_valid = START_CYCLES + core latency + 1 cycle.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0…
- Reset during any state: immediate return to IDLE with outputs cleared. The in-flight result is discarded and no response is produced.

Optional Feature:
- Macro TAYLOR_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without completion, go to RESP with resp_cos=24'h000000, resp_err=1 and the correct resp_id.
  - If completion and timeout coincide, completion wins (resp_err=0).
- Undefined: no counter. resp_err is tied 0 and WAIT waits indefinitely.

Decomposition:
- Package taylor_pkg contains:
  - FXP_W=24, FXP_FRAC=10, FXP_ONE=24'd1024.
  - typedef fxp_t (logic [23:0]).
  - State enum typedef arb_state_t {IDLE, START, WAIT, RESP}.
- Sub-module rr_arbiter (NREQ): combinational one-hot grant from req vector and ptr, plus grant index output. The pointer register stays in the top block.

Test Plan:
- Reset then a single request: req_valid[2]=1, angle 24'd0 -> req_ready[2] pulses once; core_start high exactly 3 cycles; resp_valid with resp_id=2, resp_cos=1024 ±2 LSB, resp_err=0.
- Round-robin fairness: all 4 requesters valid with angles 0, 102, 512, 1024 -> grants in order 0,1,2,3. Cosines are 1024, ~1019, ~899, ~553 (±2 LSB), each tagged with the correct id.
- Response backpressure: hold resp_ready=0 for 20 cycles -> resp outputs stable, no new req_ready pulse, busy=1. Release -> next grant in the cycle after the transfer.
- Stale ready: a behavioural core model holds ready_out high from the previous operation -> no completion until a fresh rising edge. The captured cos equals the new value.
- Reset mid-WAIT: assert reset for 1 cycle -> all outputs 0 and state IDLE. The pending requester is re-granted afterwards and no stale response appears.
- With TAYLOR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the core model never asserts ready -> 16 WAIT cycles, then resp_err=1, resp_cos=0, correct resp_id. The next request completes normally.
